// File: rtl/arc4_sequencer.sv
// ARC4 pass controller: sequences init -> ksa -> prga over the rdy/en handshake,
// owns the S-memory port mux, and adds abort plus a per-phase watchdog.
module arc4_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    output logic       rdy_o,
    input  logic       abort_i,
    output logic       done_o,
    output logic       err_o,
    output logic [2:0] phase_o,

    output logic       init_en_o,
    output logic       ksa_en_o,
    output logic       prga_en_o,
    input  logic       init_rdy_i,
    input  logic       ksa_rdy_i,
    input  logic       prga_rdy_i,

    input  logic [7:0] init_addr_i,
    input  logic [7:0] init_wrdata_i,
    input  logic       init_wren_i,
    input  logic [7:0] ksa_addr_i,
    input  logic [7:0] ksa_wrdata_i,
    input  logic       ksa_wren_i,
    input  logic [7:0] prga_addr_i,
    input  logic [7:0] prga_wrdata_i,
    input  logic       prga_wren_i,

    output logic [7:0] s_addr_o,
    output logic [7:0] s_wrdata_o,
    output logic       s_wren_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam bit WDOG_ON = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT_REQ  = 3'd1,
        ST_INIT_BUSY = 3'd2,
        ST_KSA_REQ   = 3'd3,
        ST_KSA_BUSY  = 3'd4,
        ST_PRGA_REQ  = 3'd5,
        ST_PRGA_BUSY = 3'd6,
        ST_ERROR     = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_q, rdy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             init_en_q, init_en_d;
    logic             ksa_en_q, ksa_en_d;
    logic             prga_en_q, prga_en_d;

    logic             busy_rdy;
    logic             first_busy;
    logic             timeout_hit;
    logic [CNT_W-1:0] cnt_inc;

    // Ready of whichever sub-block owns the current BUSY phase.
    always_comb begin
        busy_rdy = 1'b0;
        case (state_q)
            ST_INIT_BUSY: busy_rdy = init_rdy_i;
            ST_KSA_BUSY:  busy_rdy = ksa_rdy_i;
            ST_PRGA_BUSY: busy_rdy = prga_rdy_i;
            default:      busy_rdy = 1'b0;
        endcase
    end

    // The counter is cleared on BUSY entry and only grows, so zero marks the first BUSY cycle.
    assign first_busy  = (cnt_q == '0);
    assign timeout_hit = WDOG_ON && (cnt_q == CNT_LIMIT);
    assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        done_d    = 1'b0;
        init_en_d = 1'b0;
        ksa_en_d  = 1'b0;
        prga_en_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (en_i) begin
                    state_d = ST_INIT_REQ;
                end
            end
            ST_INIT_REQ: begin
                if (init_rdy_i) begin
                    state_d   = ST_INIT_BUSY;
                    init_en_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            ST_KSA_REQ: begin
                if (ksa_rdy_i) begin
                    state_d  = ST_KSA_BUSY;
                    ksa_en_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            ST_PRGA_REQ: begin
                if (prga_rdy_i) begin
                    state_d   = ST_PRGA_BUSY;
                    prga_en_d = 1'b1;
                    cnt_d     = '0;
                end
            end
            ST_INIT_BUSY, ST_KSA_BUSY, ST_PRGA_BUSY: begin
                if (!first_busy && busy_rdy) begin
                    case (state_q)
                        ST_INIT_BUSY: state_d = ST_KSA_REQ;
                        ST_KSA_BUSY:  state_d = ST_PRGA_REQ;
                        default: begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end
                    endcase
                end else if (timeout_hit && !busy_rdy) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_ERROR: begin
                if (en_i) begin
                    state_d = ST_INIT_REQ;
                    err_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over start and completion; err stays as it was.
        if (abort_i) begin
            state_d   = ST_IDLE;
            cnt_d     = cnt_q;
            err_d     = err_q;
            done_d    = 1'b0;
            init_en_d = 1'b0;
            ksa_en_d  = 1'b0;
            prga_en_d = 1'b0;
        end
    end

    assign rdy_d = (state_d == ST_IDLE) || (state_d == ST_ERROR);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rdy_q     <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            init_en_q <= 1'b0;
            ksa_en_q  <= 1'b0;
            prga_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdy_q     <= rdy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            init_en_q <= init_en_d;
            ksa_en_q  <= ksa_en_d;
            prga_en_q <= prga_en_d;
        end
    end

    // S-memory port follows the state register, so reset silences it immediately.
    always_comb begin
        s_addr_o   = 8'h00;
        s_wrdata_o = 8'h00;
        s_wren_o   = 1'b0;
        case (state_q)
            ST_INIT_REQ, ST_INIT_BUSY: begin
                s_addr_o   = init_addr_i;
                s_wrdata_o = init_wrdata_i;
                s_wren_o   = init_wren_i;
            end
            ST_KSA_REQ, ST_KSA_BUSY: begin
                s_addr_o   = ksa_addr_i;
                s_wrdata_o = ksa_wrdata_i;
                s_wren_o   = ksa_wren_i;
            end
            ST_PRGA_REQ, ST_PRGA_BUSY: begin
                s_addr_o   = prga_addr_i;
                s_wrdata_o = prga_wrdata_i;
                s_wren_o   = prga_wren_i;
            end
            default: begin
                s_addr_o   = 8'h00;
                s_wrdata_o = 8'h00;
                s_wren_o   = 1'b0;
            end
        endcase
    end

    assign rdy_o     = rdy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign phase_o   = state_q;
    assign init_en_o = init_en_q;
    assign ksa_en_o  = ksa_en_q;
    assign prga_en_o = prga_en_q;

endmodule

// File: tb/tb_arc4_sequencer.sv
// Directed bench for arc4_sequencer: sub-block models with fixed busy lengths,
// a long-timeout instance for normal runs and a 16-cycle-timeout instance for the watchdog.
module tb_arc4_sequencer;

    localparam int INIT_LEN = 10;
    localparam int KSA_LEN  = 40;
    localparam int PRGA_LEN = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic abort = 1'b0;
    logic sel_b = 1'b0;

    always #5 clk = ~clk;

    // Sub-block model state and stimulus overrides
    logic init_busy = 1'b0, ksa_busy = 1'b0, prga_busy = 1'b0;
    int   init_cnt = 0, ksa_cnt = 0, prga_cnt = 0;
    logic ksa_stuck = 1'b0, ksa_force = 1'b0, ovr_ksa = 1'b0, init_gate = 1'b1;

    logic       init_rdy, ksa_rdy, prga_rdy;
    logic [7:0] init_addr, init_wrdata, ksa_addr, ksa_wrdata, prga_addr, prga_wrdata;
    logic       init_wren, ksa_wren, prga_wren;

    assign init_rdy    = ~init_busy;
    assign ksa_rdy     = (~ksa_busy | ksa_force) & ~ksa_stuck;
    assign prga_rdy    = ~prga_busy;
    assign init_addr   = 8'h11;
    assign init_wrdata = 8'hA1;
    assign init_wren   = init_busy & init_gate;
    assign ksa_addr    = ovr_ksa ? 8'h55 : 8'h22;
    assign ksa_wrdata  = 8'hB2;
    assign ksa_wren    = ksa_busy | ovr_ksa;
    assign prga_addr   = 8'h33;
    assign prga_wrdata = 8'hC3;
    assign prga_wren   = prga_busy;

    logic       a_rdy, a_done, a_err, a_init_en, a_ksa_en, a_prga_en, a_s_wren;
    logic [2:0] a_phase;
    logic [7:0] a_s_addr, a_s_wrdata;
    logic       b_rdy, b_done, b_err, b_init_en, b_ksa_en, b_prga_en, b_s_wren;
    logic [2:0] b_phase;
    logic [7:0] b_s_addr, b_s_wrdata;
    logic       en_a, en_b;

    assign en_a = en & ~sel_b;
    assign en_b = en & sel_b;

    arc4_sequencer #(.TIMEOUT_CYCLES(4096)) dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en_a), .rdy_o(a_rdy), .abort_i(abort),
        .done_o(a_done), .err_o(a_err), .phase_o(a_phase),
        .init_en_o(a_init_en), .ksa_en_o(a_ksa_en), .prga_en_o(a_prga_en),
        .init_rdy_i(init_rdy), .ksa_rdy_i(ksa_rdy), .prga_rdy_i(prga_rdy),
        .init_addr_i(init_addr), .init_wrdata_i(init_wrdata), .init_wren_i(init_wren),
        .ksa_addr_i(ksa_addr), .ksa_wrdata_i(ksa_wrdata), .ksa_wren_i(ksa_wren),
        .prga_addr_i(prga_addr), .prga_wrdata_i(prga_wrdata), .prga_wren_i(prga_wren),
        .s_addr_o(a_s_addr), .s_wrdata_o(a_s_wrdata), .s_wren_o(a_s_wren)
    );

    arc4_sequencer #(.TIMEOUT_CYCLES(16)) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en_b), .rdy_o(b_rdy), .abort_i(abort),
        .done_o(b_done), .err_o(b_err), .phase_o(b_phase),
        .init_en_o(b_init_en), .ksa_en_o(b_ksa_en), .prga_en_o(b_prga_en),
        .init_rdy_i(init_rdy), .ksa_rdy_i(ksa_rdy), .prga_rdy_i(prga_rdy),
        .init_addr_i(init_addr), .init_wrdata_i(init_wrdata), .init_wren_i(init_wren),
        .ksa_addr_i(ksa_addr), .ksa_wrdata_i(ksa_wrdata), .ksa_wren_i(ksa_wren),
        .prga_addr_i(prga_addr), .prga_wrdata_i(prga_wrdata), .prga_wren_i(prga_wren),
        .s_addr_o(b_s_addr), .s_wrdata_o(b_s_wrdata), .s_wren_o(b_s_wren)
    );

    logic       rdy, done, err, init_en, ksa_en, prga_en, s_wren;
    logic [2:0] phase;
    logic [7:0] s_addr, s_wrdata;

    assign rdy      = sel_b ? b_rdy      : a_rdy;
    assign done     = sel_b ? b_done     : a_done;
    assign err      = sel_b ? b_err      : a_err;
    assign phase    = sel_b ? b_phase    : a_phase;
    assign init_en  = sel_b ? b_init_en  : a_init_en;
    assign ksa_en   = sel_b ? b_ksa_en   : a_ksa_en;
    assign prga_en  = sel_b ? b_prga_en  : a_prga_en;
    assign s_addr   = sel_b ? b_s_addr   : a_s_addr;
    assign s_wrdata = sel_b ? b_s_wrdata : a_s_wrdata;
    assign s_wren   = sel_b ? b_s_wren   : a_s_wren;

    // Sub-block models: drop rdy the edge after en, busy for a fixed number of cycles.
    always @(posedge clk) begin
        if (init_en) begin init_busy <= 1'b1; init_cnt <= INIT_LEN; end
        else if (init_busy) begin
            if (init_cnt <= 1) init_busy <= 1'b0; else init_cnt <= init_cnt - 1;
        end
        if (ksa_en) begin ksa_busy <= 1'b1; ksa_cnt <= KSA_LEN; end
        else if (ksa_busy) begin
            if (ksa_cnt <= 1) ksa_busy <= 1'b0; else ksa_cnt <= ksa_cnt - 1;
        end
        if (prga_en) begin prga_busy <= 1'b1; prga_cnt <= PRGA_LEN; end
        else if (prga_busy) begin
            if (prga_cnt <= 1) prga_busy <= 1'b0; else prga_cnt <= prga_cnt - 1;
        end
    end

    // Event monitor, sampled late in the low half of the clock.
    int   n_init_en = 0, n_ksa_en = 0, n_prga_en = 0, n_done = 0, mux_bad = 0, dbl_done = 0;
    int   ev_q[$];
    logic prev_done = 1'b0;
    logic [7:0] e_addr, e_data;
    logic       e_wren;

    always begin
        @(negedge clk);
        #4;
        if (init_en) begin n_init_en++; ev_q.push_back(1); end
        if (ksa_en)  begin n_ksa_en++;  ev_q.push_back(2); end
        if (prga_en) begin n_prga_en++; ev_q.push_back(3); end
        if (done) begin
            n_done++;
            ev_q.push_back(4);
            if (prev_done) dbl_done++;
        end
        prev_done = done;
        e_addr = 8'h00; e_data = 8'h00; e_wren = 1'b0;
        case (phase)
            3'd1, 3'd2: begin e_addr = init_addr; e_data = init_wrdata; e_wren = init_wren; end
            3'd3, 3'd4: begin e_addr = ksa_addr;  e_data = ksa_wrdata;  e_wren = ksa_wren;  end
            3'd5, 3'd6: begin e_addr = prga_addr; e_data = prga_wrdata; e_wren = prga_wren; end
            default: ;
        endcase
        if ({s_addr, s_wrdata, s_wren} !== {e_addr, e_data, e_wren}) mux_bad++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_en();
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
    endtask

    task automatic wait_phase(input logic [2:0] p, input int budget, input string tag);
        int k = 0;
        while (phase !== p && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(phase), 32'(p));
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_bfm_idle(input string tag);
        int k = 0;
        while ((init_busy | ksa_busy | prga_busy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'({init_busy, ksa_busy, prga_busy}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int b_init, b_ksa, b_prga, b_done, b_ev, b_mux, n;
        int exp_ev[8];
        exp_ev = '{1, 2, 3, 4, 1, 2, 3, 4};

        // T1: reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_en", 32'({init_en, ksa_en, prga_en}), 32'd0);
        chk("rst_s_wren", 32'(s_wren), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;

        // T2: full run, then back-to-back start with the mux probe (T3) inside it
        b_init = n_init_en; b_ksa = n_ksa_en; b_prga = n_prga_en; b_done = n_done;
        b_ev = ev_q.size(); b_mux = mux_bad;
        pulse_en();
        chk("t2_req_phase", 32'(phase), 32'd1);
        chk("t2_req_rdy", 32'(rdy), 32'd0);
        wait_done(400, "t2_done");
        chk("t2_done_rdy", 32'(rdy), 32'd1);
        chk("t2_done_phase", 32'(phase), 32'd0);
        @(negedge clk);
        chk("t2_done_pulse", 32'(done), 32'd0);
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        chk("b2b_phase", 32'(phase), 32'd1);

        wait_phase(3'd2, 20, "t3_init_busy");
        @(negedge clk);
        ovr_ksa = 1'b1;
        #1;
        chk("t3_wren_init", 32'(s_wren), 32'd1);
        chk("t3_addr_init", 32'(s_addr), 32'h11);
        chk("t3_data_init", 32'(s_wrdata), 32'hA1);
        init_gate = 1'b0;
        #1;
        chk("t3_wren_ksa_hidden", 32'(s_wren), 32'd0);
        chk("t3_addr_ksa_hidden", 32'(s_addr), 32'h11);
        init_gate = 1'b1;
        ovr_ksa = 1'b0;

        wait_done(400, "b2b_done");
        repeat (3) @(negedge clk);
        chk("t2_n_init_en", 32'(n_init_en - b_init), 32'd2);
        chk("t2_n_ksa_en", 32'(n_ksa_en - b_ksa), 32'd2);
        chk("t2_n_prga_en", 32'(n_prga_en - b_prga), 32'd2);
        chk("t2_n_done", 32'(n_done - b_done), 32'd2);
        chk("t2_ev_count", 32'(ev_q.size() - b_ev), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_ev%0d", i), 32'(ev_q[b_ev + i]), 32'(exp_ev[i]));
        end
        chk("t2_mux", 32'(mux_bad - b_mux), 32'd0);
        chk("t2_dbl_done", 32'(dbl_done), 32'd0);

        // T4: watchdog on the 16-cycle instance
        wait_bfm_idle("t4_idle");
        sel_b = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pulse_en();
        wait_phase(3'd4, 100, "t4_ksa_busy");
        ksa_stuck = 1'b1;
        n = 1;
        while (phase === 3'd4 && n < 100) begin
            @(negedge clk);
            if (phase === 3'd4) n++;
        end
        chk("t4_busy_cycles", 32'(n), 32'd17);
        chk("t4_err_phase", 32'(phase), 32'd7);
        chk("t4_err_flag", 32'(err), 32'd1);
        chk("t4_err_rdy", 32'(rdy), 32'd1);
        b_prga = n_prga_en;
        repeat (3) @(negedge clk);
        chk("t4_err_hold", 32'({phase, err}), 32'({3'd7, 1'b1}));
        chk("t4_no_en_in_err", 32'(n_prga_en - b_prga), 32'd0);
        pulse_en();
        chk("t4_restart_phase", 32'(phase), 32'd1);
        chk("t4_restart_err", 32'(err), 32'd0);
        chk("t4_restart_rdy", 32'(rdy), 32'd0);
        ksa_stuck = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t4_abort_phase", 32'(phase), 32'd0);

        // T5: abort in KSA_BUSY together with ksa_rdy
        wait_bfm_idle("t5_idle");
        sel_b = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        b_prga = n_prga_en; b_done = n_done;
        pulse_en();
        wait_phase(3'd4, 100, "t5_ksa_busy");
        repeat (2) @(negedge clk);
        ksa_force = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        ksa_force = 1'b0;
        chk("t5_phase", 32'(phase), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_rdy", 32'(rdy), 32'd1);
        repeat (5) @(negedge clk);
        chk("t5_no_prga_en", 32'(n_prga_en - b_prga), 32'd0);
        chk("t5_no_done", 32'(n_done - b_done), 32'd0);

        // T6: reset during PRGA_BUSY, then a full run
        wait_bfm_idle("t6_idle");
        pulse_en();
        wait_phase(3'd6, 200, "t6_prga_busy");
        @(negedge clk);
        chk("t6_prga_wren", 32'(s_wren), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_phase", 32'(phase), 32'd0);
        chk("t6_rst_s_wren", 32'(s_wren), 32'd0);
        chk("t6_rst_rdy", 32'(rdy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        wait_bfm_idle("t6_idle2");
        b_init = n_init_en; b_ksa = n_ksa_en; b_prga = n_prga_en; b_done = n_done;
        b_mux = mux_bad;
        pulse_en();
        wait_done(400, "t6_done");
        repeat (3) @(negedge clk);
        chk("t6_n_en", 32'({8'(n_init_en - b_init), 8'(n_ksa_en - b_ksa), 8'(n_prga_en - b_prga)}),
            32'h010101);
        chk("t6_n_done", 32'(n_done - b_done), 32'd1);
        chk("t6_mux", 32'(mux_bad - b_mux), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
